// File: rtl/sample_window_queue.sv
// sample_window_queue: multi-channel circular sample queue feeding the FIR MAC.
// Keeps the newest TAPS samples of NCH channels in per-channel dual-port RAM and,
// on every accepted write once the window is full, streams the window oldest to
// newest at one sample per clock. Adds input decimation, a synchronous flush and
// sticky overrun detection for strobes that arrive while a window is in flight.
module sample_window_queue #(
  parameter int DW    = 16,
  parameter int NCH   = 2,
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021,
  parameter int DECIM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic [NCH*DW-1:0] smpl_in,
  input  logic              flush,
  output logic [NCH*DW-1:0] smpl_out,
  output logic              sequencing,
  output logic              done,
  output logic              full,
  output logic              overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam int RW = $clog2(TAPS);

  localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TAPS);
  localparam logic [RW-1:0] RD_LAST  = RW'(TAPS - 1);
  localparam logic [3:0]    DEC_LAST = 4'(DECIM - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] new_ptr;
  logic [AW-1:0] old_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rd_cnt;
  logic [3:0]    dec_cnt;

  logic strobe_ok;  // strobe arrived while the queue can take it
  logic accept;     // strobe survives decimation and is written
  logic go_read;    // accepted write that completes or slides the window
  logic rd_en;      // a RAM address is presented this cycle
  logic rd_last;    // the address presented is the newest sample

  // State register: IDLE between windows, READ while addresses are presented.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: flush abandons any window in progress.
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves
    // state_nx unassigned and no latch is inferred.
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (go_read) state_nx = READ;
        READ: if (rd_last) state_nx = IDLE;
      endcase
    end
  end

  // Output/control decode: strobe qualification and read-address control.
  always_comb begin
    strobe_ok = wrt_smpl && (state == IDLE) && !sequencing;
    accept    = strobe_ok && (dec_cnt == 4'd0) && !flush;
    go_read   = accept && (cnt >= CNT_LAST);
    rd_en     = (state == READ);
    rd_last   = rd_en && (rd_cnt == RD_LAST);
  end

  // Pointer, fill, decimation and status bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      dec_cnt    <= '0;
      full       <= 1'b0;
      overrun    <= 1'b0;
      sequencing <= 1'b0;
      done       <= 1'b0;
    end else if (flush) begin
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      dec_cnt    <= '0;
      full       <= 1'b0;
      overrun    <= 1'b0;
      sequencing <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Only strobes that the queue could take count toward decimation.
      if (strobe_ok) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? 4'd0 : dec_cnt + 4'd1;
      end
      if (wrt_smpl && !strobe_ok) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        new_ptr <= new_ptr + PTR_ONE;
        if (cnt < CNT_LAST) begin
          cnt <= cnt + CW'(1);
        end else if (cnt == CNT_LAST) begin
          // First complete window starts at the very first stored sample.
          cnt    <= CNT_FULL;
          full   <= 1'b1;
          rd_ptr <= old_ptr;
        end else begin
          // Window slides by one: drop the oldest sample.
          old_ptr <= old_ptr + PTR_ONE;
          rd_ptr  <= old_ptr + PTR_ONE;
        end
      end

      // rd_ptr loads only in IDLE and advances only in READ, so no conflict.
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_cnt <= rd_last ? '0 : rd_cnt + RW'(1);
      end

      // Delayed one cycle so both flags line up with the RAM read register.
      sequencing <= rd_en;
      done       <= rd_last;
    end
  end

  // Per-channel sample RAM with registered read port.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;

    // Write the accepted sample; read the presented window address.
    always_ff @(posedge clk) begin
      // NOTE: the RAM and its read register have no reset so they map onto
      // block RAM; their contents are only looked at while sequencing is high.
      if (accept) mem[new_ptr] <= smpl_in[k*DW +: DW];
      if (rd_en)  rd_q <= mem[rd_ptr];
    end

    assign smpl_out[k*DW +: DW] = rd_q;
  end

endmodule
